// File: rtl/plot_sequencer.sv
// Pixel-command generator for the 160x120 VGA adapter plot port: expands draw/erase cell and
// clear/fill screen commands into one registered pixel write per clock. Optional macro: PLOT_SEQ_ABORT_EN.
module plot_sequencer #(
  parameter int X_MAX = 160,
  parameter int Y_MAX = 120,
  parameter int CELL  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_x,
  input  logic [6:0] cmd_y,
  input  logic [2:0] cmd_colour,
  input  logic       abort,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CELL   = 2'd1;
  localparam logic [1:0] S_SCREEN = 2'd2;

  localparam logic [7:0] CELL_LAST_X = 8'(CELL - 1);
  localparam logic [6:0] CELL_LAST_Y = 7'(CELL - 1);
  localparam logic [7:0] SCR_LAST_X  = 8'(X_MAX - 1);
  localparam logic [6:0] SCR_LAST_Y  = 7'(Y_MAX - 1);
  localparam logic [8:0] X_LIM       = 9'(X_MAX);
  localparam logic [7:0] Y_LIM       = 8'(Y_MAX);

  logic [1:0] state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [7:0] org_x_q, org_x_d;
  logic [6:0] org_y_q, org_y_d;
  logic [2:0] col_q, col_d;
  logic [7:0] cnt_x_q, cnt_x_d;
  logic [6:0] cnt_y_q, cnt_y_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic       done_q, done_d;
  logic       ready_q, ready_d;

  logic       emit;
  logic       vis;
  logic [7:0] last_x;
  logic [6:0] last_y;
  logic [8:0] sum_x;
  logic [7:0] sum_y;

`ifndef PLOT_SEQ_ABORT_EN
  logic unused_abort;
  assign unused_abort = abort;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    org_x_d = org_x_q;
    org_y_d = org_y_q;
    col_d   = col_q;
    cnt_x_d = cnt_x_q;
    cnt_y_d = cnt_y_q;
    emit    = 1'b0;
    done_d  = 1'b0;
    last_x  = (state_q == S_SCREEN) ? SCR_LAST_X : CELL_LAST_X;
    last_y  = (state_q == S_SCREEN) ? SCR_LAST_Y : CELL_LAST_Y;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          op_d    = cmd_op;
          org_x_d = cmd_x;
          org_y_d = cmd_y;
          col_d   = cmd_colour;
          cnt_x_d = 8'd0;
          cnt_y_d = 7'd0;
          state_d = cmd_op[1] ? S_SCREEN : S_CELL;
          emit    = 1'b1;
        end
      end
      S_CELL, S_SCREEN: begin
        emit = 1'b1;
        if (cnt_x_q != last_x) begin
          cnt_x_d = cnt_x_q + 8'd1;
        end else begin
          cnt_x_d = 8'd0;
          if (cnt_y_q != last_y) begin
            cnt_y_d = cnt_y_q + 7'd1;
          end else begin
            cnt_y_d = 7'd0;
            state_d = S_IDLE;
            emit    = 1'b0;
            done_d  = 1'b1;
          end
        end
`ifdef PLOT_SEQ_ABORT_EN
        if (abort) begin
          cnt_x_d = 8'd0;
          cnt_y_d = 7'd0;
          state_d = S_IDLE;
          emit    = 1'b0;
          done_d  = 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Output registers are loaded with the pixel the counters will hold after this edge.
    sum_x = {1'b0, org_x_d} + {1'b0, cnt_x_d};
    sum_y = {1'b0, org_y_d} + {1'b0, cnt_y_d};
    if (state_d == S_SCREEN) begin
      x_d = cnt_x_d;
      y_d = cnt_y_d;
      vis = 1'b1;
    end else begin
      x_d = sum_x[7:0];
      y_d = sum_y[6:0];
      vis = (sum_x < X_LIM) && (sum_y < Y_LIM);
    end
    if (!emit) begin
      x_d = 8'd0;
      y_d = 7'd0;
    end
    plot_d   = emit && vis;
    colour_d = (emit && (op_d == 2'b00 || op_d == 2'b11)) ? col_d : 3'b000;
    ready_d  = (state_d == S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      org_x_q  <= 8'd0;
      org_y_q  <= 7'd0;
      col_q    <= 3'b000;
      cnt_x_q  <= 8'd0;
      cnt_y_q  <= 7'd0;
      x_q      <= 8'd0;
      y_q      <= 7'd0;
      colour_q <= 3'b000;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      org_x_q  <= org_x_d;
      org_y_q  <= org_y_d;
      col_q    <= col_d;
      cnt_x_q  <= cnt_x_d;
      cnt_y_q  <= cnt_y_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign colour    = colour_q;
  assign plot      = plot_q;
  assign done      = done_q;
  assign cmd_ready = ready_q;

endmodule

// File: tb/tb_plot_sequencer.sv
// Self-checking bench for plot_sequencer: directed and random commands compared cycle by cycle
// against a pixel-list reference model built from nested loops over the command's area.
module tb_plot_sequencer;

  localparam int X_MAX = 160;
  localparam int Y_MAX = 120;
  localparam int CELL  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_x;
  logic [6:0] cmd_y;
  logic [2:0] cmd_colour;
  logic       abort;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [20:0] exp_q[$];

  plot_sequencer #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .CELL(CELL)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_colour(cmd_colour),
    .abort     (abort),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // {plot, x, y, colour, done, cmd_ready}; colour only matters on plotted cycles.
  function automatic logic [20:0] word(input bit vis, input int px, input int py, input logic [2:0] c);
    logic [31:0] a;
    logic [31:0] b;
    a = px;
    b = py;
    return {vis, a[7:0], b[6:0], vis ? c : 3'b000, 2'b00};
  endfunction

  function automatic logic [20:0] obs_word();
    return {plot, x, y, plot ? colour : 3'b000, done, cmd_ready};
  endfunction

  task automatic build(input logic [1:0] op, input logic [7:0] ox, input logic [6:0] oy, input logic [2:0] col);
    logic [2:0] c;
    int px;
    int py;
    exp_q.delete();
    c = (op == 2'b00 || op == 2'b11) ? col : 3'b000;
    if (op == 2'b10 || op == 2'b11) begin
      for (int j = 0; j < Y_MAX; j++)
        for (int i = 0; i < X_MAX; i++) exp_q.push_back(word(1'b1, i, j, c));
    end else begin
      for (int j = 0; j < CELL; j++)
        for (int i = 0; i < CELL; i++) begin
          px = int'(ox) + i;
          py = int'(oy) + j;
          exp_q.push_back(word(px < X_MAX && py < Y_MAX, px, py, c));
        end
    end
  endtask

  // Present a command, wait (bounded) for ready, let the accepting edge pass.
  task automatic start_cmd(input logic [1:0] op, input logic [7:0] ox, input logic [6:0] oy,
                           input logic [2:0] col, input bit hold, output int waited);
    cmd_op     = op;
    cmd_x      = ox;
    cmd_y      = oy;
    cmd_colour = col;
    cmd_valid  = 1'b1;
    waited     = 0;
    while (!cmd_ready && waited < 200) begin
      tick();
      waited++;
    end
    if (waited >= 200) check("ready_timeout", 32'd0, 32'd1);
    tick();
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] ox, input logic [6:0] oy,
                         input logic [2:0] col, input bit hold, output int waited);
    build(op, ox, oy, col);
    start_cmd(op, ox, oy, col, hold, waited);
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("pix%0d_op%0d", i, op), 32'(obs_word()), 32'(exp_q[i]));
      tick();
    end
    check("done_cycle", {29'd0, plot, done, cmd_ready}, 32'b011);
    if (!hold) begin
      tick();
      check("done_once", {29'd0, plot, done, cmd_ready}, 32'b001);
    end
  endtask

  initial begin
    int w;
    logic [7:0] rx;
    reset      = 1'b1;
    cmd_valid  = 1'b1;
    cmd_op     = 2'b11;
    cmd_x      = 8'd5;
    cmd_y      = 7'd5;
    cmd_colour = 3'b111;
    abort      = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_state", {11'd0, obs_word()}, 32'd0);
    end
    reset     = 1'b0;
    cmd_valid = 1'b0;
    tick();
    check("ready_after_reset", {29'd0, plot, done, cmd_ready}, 32'b001);

    run_cmd(2'b00, 8'd10, 7'd20, 3'b100, 1'b0, w);
    run_cmd(2'b00, 8'd159, 7'd119, 3'b101, 1'b0, w);
    run_cmd(2'b01, 8'd159, 7'd119, 3'b111, 1'b0, w);
    run_cmd(2'b10, 8'd77, 7'd33, 3'b110, 1'b0, w);

    run_cmd(2'b11, 8'd0, 7'd0, 3'b010, 1'b1, w);
    run_cmd(2'b00, 8'd30, 7'd40, 3'b001, 1'b0, w);
    check("b2b_no_wait", 32'(w), 32'd0);

    for (int n = 0; n < 24; n++) begin
      rx = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(150, 170)) : 8'($urandom_range(0, 255));
      run_cmd(2'($urandom_range(0, 1)), rx, 7'($urandom_range(0, 127)), 3'($urandom), n[0], w);
      if (n[0]) begin
        cmd_valid = 1'b0;
        tick();
        check("rand_done_once", {29'd0, plot, done, cmd_ready}, 32'b001);
      end
    end

    build(2'b10, 8'd0, 7'd0, 3'b000);
    start_cmd(2'b10, 8'd0, 7'd0, 3'b000, 1'b0, w);
    for (int i = 0; i <= 5000; i++) begin
      check($sformatf("rst_pix%0d", i), 32'(obs_word()), 32'(exp_q[i]));
      if (i < 5000) tick();
    end
    reset = 1'b1;
    tick();
    check("reset_mid_scan", {29'd0, plot, done, cmd_ready}, 32'b000);
    reset = 1'b0;
    tick();
    check("reset_no_done", {29'd0, plot, done, cmd_ready}, 32'b001);
    tick();
    check("reset_still_idle", {29'd0, plot, done, cmd_ready}, 32'b001);

    build(2'b10, 8'd0, 7'd0, 3'b000);
    start_cmd(2'b10, 8'd0, 7'd0, 3'b000, 1'b0, w);
    for (int i = 0; i <= 5000; i++) begin
      check($sformatf("abort_pix%0d", i), 32'(obs_word()), 32'(exp_q[i]));
      if (i < 5000) tick();
    end
    abort = 1'b1;
    tick();
`ifdef PLOT_SEQ_ABORT_EN
    check("abort_stop", {29'd0, plot, done, cmd_ready}, 32'b011);
    abort = 1'b0;
    tick();
    check("abort_done_once", {29'd0, plot, done, cmd_ready}, 32'b001);
`else
    for (int i = 5001; i < exp_q.size(); i++) begin
      check($sformatf("noabort_pix%0d", i), 32'(obs_word()), 32'(exp_q[i]));
      if (i == 5001) abort = 1'b0;
      tick();
    end
    check("noabort_done", {29'd0, plot, done, cmd_ready}, 32'b011);
    tick();
    check("noabort_done_once", {29'd0, plot, done, cmd_ready}, 32'b001);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
